// File: rtl/pipe_hazard_scoreboard.sv
// Hazard, interlock and forwarding controller for a parametrised in-order pipeline.
// A shift-register scoreboard tracks every instruction from EX (stage 1) to WB
// (stage DEPTH). ID is stalled when a source operand cannot be forwarded by the time
// the consumer reaches EX; the EX-stage consumer gets per-operand forward selects.
module pipe_hazard_scoreboard #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned DEPTH    = 4,  // 3..8
    parameter int unsigned LOAD_RDY = 3,
    parameter int unsigned MUL_RDY  = 4,  // <= DEPTH
    parameter int unsigned BR_STAGE = 2,  // 1..DEPTH-1
    parameter int unsigned SEL_W    = 3   // 2**SEL_W > DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic [1:0]        id_class,
    input  logic              redirect,
    output logic              stall,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [DEPTH-1:0]  flush_stg,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic [15:0]       stall_count
);

    // Ready stage never exceeds 8, so four bits suffice.
    localparam int unsigned RdyW = 4;

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [REG_AW-1:0] wr_reg;
        logic [RdyW-1:0]   rdy;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              rs_used;
        logic              rt_used;
    } entry_t;

    // Index k-1 holds the instruction currently in stage k.
    entry_t          stg_q [DEPTH];
    entry_t          stg_d [DEPTH];
    logic [RdyW-1:0] id_rdy;
    logic            id_haz;
    logic [15:0]     stall_count_q;
    logic [15:0]     stall_count_d;

    // Ready stage of the ID instruction by result class; LINK behaves like ALU.
    always_comb begin
        case (id_class)
            2'd1:    id_rdy = RdyW'(LOAD_RDY);
            2'd2:    id_rdy = RdyW'(MUL_RDY);
            default: id_rdy = RdyW'(2);
        endcase
    end

    // Interlock: an operand is hazardous if its producer will not be forwardable
    // when the consumer reaches EX next cycle. Redirect wins over stall.
    always_comb begin
        id_haz = 1'b0;
        for (int s = 1; s <= int'(DEPTH); s++) begin
            if (stg_q[s-1].valid && stg_q[s-1].wr_en && (s + 1 < int'(stg_q[s-1].rdy))) begin
                if (id_rs_used && (id_rs != '0) && (stg_q[s-1].wr_reg == id_rs)) begin
                    id_haz = 1'b1;
                end
                if (id_rt_used && (id_rt != '0) && (stg_q[s-1].wr_reg == id_rt)) begin
                    id_haz = 1'b1;
                end
            end
        end
        stall = id_valid && id_haz && !redirect;
    end

    // Redirect kills the front end and every stage younger than the branch.
    always_comb begin
        flush_ifid = redirect;
        flush_idex = redirect;
        for (int k = 0; k < int'(DEPTH); k++) begin
            flush_stg[k] = redirect && (k + 1 < int'(BR_STAGE));
        end
    end

    // Forward select for the EX entry: the youngest older writer decides; if it
    // is not yet ready the select falls back to 0 (the interlock prevents this).
    always_comb begin
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        if (stg_q[0].valid) begin
            for (int s = int'(DEPTH); s >= 2; s--) begin
                if (stg_q[s-1].valid && stg_q[s-1].wr_en) begin
                    if (stg_q[0].rs_used && (stg_q[0].rs != '0) &&
                        (stg_q[s-1].wr_reg == stg_q[0].rs)) begin
                        fwd_rs_sel = (int'(stg_q[s-1].rdy) <= s) ? SEL_W'(s) : '0;
                    end
                    if (stg_q[0].rt_used && (stg_q[0].rt != '0) &&
                        (stg_q[s-1].wr_reg == stg_q[0].rt)) begin
                        fwd_rt_sel = (int'(stg_q[s-1].rdy) <= s) ? SEL_W'(s) : '0;
                    end
                end
            end
        end
    end

    // Next scoreboard: stages always advance; only EX entry depends on stall.
    always_comb begin
        stg_d[0] = '0;
        if (id_valid && !stall && !redirect) begin
            stg_d[0].valid   = 1'b1;
            stg_d[0].wr_en   = id_wr_en;
            stg_d[0].wr_reg  = id_wr_reg;
            stg_d[0].rdy     = id_rdy;
            stg_d[0].rs      = id_rs;
            stg_d[0].rt      = id_rt;
            stg_d[0].rs_used = id_rs_used;
            stg_d[0].rt_used = id_rt_used;
        end
        for (int k = 1; k < int'(DEPTH); k++) begin
            stg_d[k] = stg_q[k-1];
            if (flush_stg[k-1]) begin
                stg_d[k].valid = 1'b0;
            end
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Scoreboard shift register; the WB entry simply falls off the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Self-checking bench for pipe_hazard_scoreboard (default parameters).
// Each test queues per-cycle stimulus with its expected outputs, then replays it.
module tb_pipe_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        id_wr_en;
    logic [4:0]  id_wr_reg;
    logic [1:0]  id_class;
    logic        redirect;
    logic        stall;
    logic        flush_ifid;
    logic        flush_idex;
    logic [3:0]  flush_stg;
    logic [2:0]  fwd_rs_sel;
    logic [2:0]  fwd_rt_sel;
    logic [15:0] stall_count;

    pipe_hazard_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_wr_en   (id_wr_en),
        .id_wr_reg  (id_wr_reg),
        .id_class   (id_class),
        .redirect   (redirect),
        .stall      (stall),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex),
        .flush_stg  (flush_stg),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] cls;
        logic       we;
        logic [4:0] wr;
        logic [4:0] rs;
        logic       rsu;
        logic [4:0] rt;
        logic       rtu;
        logic       redir;
    } stim_t;

    typedef struct {
        string       name;
        logic        stall;
        logic        flush;
        logic [3:0]  fstg;
        logic [2:0]  rs_sel;
        logic [2:0]  rt_sel;
        logic [15:0] cnt;
    } exp_t;

    stim_t       stim_q[$];
    exp_t        exp_q[$];
    int          n_run  = 0;
    int          n_fail = 0;
    logic [15:0] model_cnt = 16'd0;

    localparam logic [1:0] ALU  = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;

    function automatic stim_t mk(input logic v, input logic [1:0] cls, input logic we,
                                 input logic [4:0] wr, input logic [4:0] rs, input logic rsu,
                                 input logic [4:0] rt, input logic rtu, input logic redir,
                                 input logic r);
        stim_t s;
        s.r = r; s.v = v; s.cls = cls; s.we = we; s.wr = wr;
        s.rs = rs; s.rsu = rsu; s.rt = rt; s.rtu = rtu; s.redir = redir;
        return s;
    endfunction

    function automatic stim_t nop();
        return mk(1'b0, ALU, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic apply(input stim_t s);
        rst        = s.r;
        id_valid   = s.v;
        id_class   = s.cls;
        id_wr_en   = s.we;
        id_wr_reg  = s.wr;
        id_rs      = s.rs;
        id_rs_used = s.rsu;
        id_rt      = s.rt;
        id_rt_used = s.rtu;
        redirect   = s.redir;
    endtask

    // Queue one cycle of stimulus with its expectation; BR_STAGE=2 means a redirect
    // kills only stage 1. The counter expectation is the count before this cycle.
    task automatic push(input string nm, input stim_t s, input logic st,
                        input logic [2:0] rss, input logic [2:0] rts);
        exp_t e;
        e.name   = nm;
        e.stall  = st;
        e.flush  = s.redir;
        e.fstg   = s.redir ? 4'b0001 : 4'b0000;
        e.rs_sel = rss;
        e.rt_sel = rts;
        e.cnt    = model_cnt;
        stim_q.push_back(s);
        exp_q.push_back(e);
        if (s.r) model_cnt = 16'd0;
        else if (st && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        push("reset_c0", nop(), 1'b0, 3'd0, 3'd0);
        push("reset_c1", nop(), 1'b0, 3'd0, 3'd0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if ({stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel} !==
                {e.stall, e.flush, e.flush, e.fstg, e.rs_sel, e.rt_sel}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fl=%b%b stg=%b rs=%0d rt=%0d want stall=%b fl=%b stg=%b rs=%0d rt=%0d",
                         e.name, stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel,
                         e.stall, e.flush, e.fstg, e.rs_sel, e.rt_sel);
            end
            n_run++;
            if (stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d want %0d", e.name, stall_count, e.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_alu_forward();
        stim_t s;
        exp_t  e;
        push("alu_c0", mk(1, ALU, 1, 5'd8, 5'd0, 0, 5'd0, 0, 0, 0), 1'b0, 3'd0, 3'd0);
        push("alu_c1", mk(1, ALU, 0, 5'd0, 5'd8, 1, 5'd0, 0, 0, 0), 1'b0, 3'd0, 3'd0);
        push("alu_c2", mk(1, ALU, 0, 5'd0, 5'd0, 0, 5'd8, 1, 0, 0), 1'b0, 3'd2, 3'd0);
        push("alu_c3", mk(1, ALU, 0, 5'd0, 5'd8, 1, 5'd8, 1, 0, 0), 1'b0, 3'd0, 3'd3);
        push("alu_c4", nop(), 1'b0, 3'd4, 3'd4);
        push("alu_c5", nop(), 1'b0, 3'd0, 3'd0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if ({stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel} !==
                {e.stall, e.flush, e.flush, e.fstg, e.rs_sel, e.rt_sel}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fl=%b%b stg=%b rs=%0d rt=%0d want stall=%b fl=%b stg=%b rs=%0d rt=%0d",
                         e.name, stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel,
                         e.stall, e.flush, e.fstg, e.rs_sel, e.rt_sel);
            end
            n_run++;
            if (stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d want %0d", e.name, stall_count, e.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s;
        exp_t  e;
        stim_t rd;
        rd = mk(1, ALU, 0, 5'd0, 5'd0, 0, 5'd9, 1, 0, 0);
        push("load_c0", mk(1, LOAD, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0, 0), 1'b0, 3'd0, 3'd0);
        push("load_c1", rd, 1'b1, 3'd0, 3'd0);
        push("load_c2", rd, 1'b0, 3'd0, 3'd0);
        push("load_c3", nop(), 1'b0, 3'd0, 3'd3);
        push("load_c4", nop(), 1'b0, 3'd0, 3'd0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if ({stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel} !==
                {e.stall, e.flush, e.flush, e.fstg, e.rs_sel, e.rt_sel}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fl=%b%b stg=%b rs=%0d rt=%0d want stall=%b fl=%b stg=%b rs=%0d rt=%0d",
                         e.name, stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel,
                         e.stall, e.flush, e.fstg, e.rs_sel, e.rt_sel);
            end
            n_run++;
            if (stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d want %0d", e.name, stall_count, e.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mul_use();
        stim_t s;
        exp_t  e;
        stim_t rd;
        rd = mk(1, ALU, 0, 5'd0, 5'd10, 1, 5'd0, 0, 0, 0);
        push("mul_c0", mk(1, MUL, 1, 5'd10, 5'd0, 0, 5'd0, 0, 0, 0), 1'b0, 3'd0, 3'd0);
        push("mul_c1", rd, 1'b1, 3'd0, 3'd0);
        push("mul_c2", rd, 1'b1, 3'd0, 3'd0);
        push("mul_c3", rd, 1'b0, 3'd0, 3'd0);
        push("mul_c4", nop(), 1'b0, 3'd4, 3'd0);
        push("mul_c5", nop(), 1'b0, 3'd0, 3'd0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if ({stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel} !==
                {e.stall, e.flush, e.flush, e.fstg, e.rs_sel, e.rt_sel}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fl=%b%b stg=%b rs=%0d rt=%0d want stall=%b fl=%b stg=%b rs=%0d rt=%0d",
                         e.name, stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel,
                         e.stall, e.flush, e.fstg, e.rs_sel, e.rt_sel);
            end
            n_run++;
            if (stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d want %0d", e.name, stall_count, e.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reg_zero();
        stim_t s;
        exp_t  e;
        push("r0_c0", mk(1, LOAD, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0), 1'b0, 3'd0, 3'd0);
        push("r0_c1", mk(1, ALU, 0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0), 1'b0, 3'd0, 3'd0);
        push("r0_c2", nop(), 1'b0, 3'd0, 3'd0);
        push("r0_c3", nop(), 1'b0, 3'd0, 3'd0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if ({stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel} !==
                {e.stall, e.flush, e.flush, e.fstg, e.rs_sel, e.rt_sel}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fl=%b%b stg=%b rs=%0d rt=%0d want stall=%b fl=%b stg=%b rs=%0d rt=%0d",
                         e.name, stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel,
                         e.stall, e.flush, e.fstg, e.rs_sel, e.rt_sel);
            end
            n_run++;
            if (stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d want %0d", e.name, stall_count, e.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Redirect while ID has a hazard; the killed load must not stall or forward later.
    task automatic test_redirect();
        stim_t s;
        exp_t  e;
        push("redir_c0", mk(1, LOAD, 1, 5'd11, 5'd0, 0, 5'd0, 0, 0, 0), 1'b0, 3'd0, 3'd0);
        push("redir_c1", mk(1, ALU, 0, 5'd0, 5'd11, 1, 5'd0, 0, 1, 0), 1'b0, 3'd0, 3'd0);
        push("redir_c2", mk(1, ALU, 0, 5'd0, 5'd11, 1, 5'd0, 0, 0, 0), 1'b0, 3'd0, 3'd0);
        push("redir_c3", nop(), 1'b0, 3'd0, 3'd0);
        push("redir_c4", nop(), 1'b0, 3'd0, 3'd0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if ({stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel} !==
                {e.stall, e.flush, e.flush, e.fstg, e.rs_sel, e.rt_sel}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fl=%b%b stg=%b rs=%0d rt=%0d want stall=%b fl=%b stg=%b rs=%0d rt=%0d",
                         e.name, stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel,
                         e.stall, e.flush, e.fstg, e.rs_sel, e.rt_sel);
            end
            n_run++;
            if (stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d want %0d", e.name, stall_count, e.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reset asserted while a MUL interlock is active.
    task automatic test_reset_mid_stall();
        stim_t s;
        exp_t  e;
        stim_t rd;
        stim_t rd_rst;
        rd     = mk(1, ALU, 0, 5'd0, 5'd12, 1, 5'd0, 0, 0, 0);
        rd_rst = mk(1, ALU, 0, 5'd0, 5'd12, 1, 5'd0, 0, 0, 1);
        push("rstm_c0", mk(1, MUL, 1, 5'd12, 5'd0, 0, 5'd0, 0, 0, 0), 1'b0, 3'd0, 3'd0);
        push("rstm_c1", rd, 1'b1, 3'd0, 3'd0);
        push("rstm_c2", rd_rst, 1'b1, 3'd0, 3'd0);
        push("rstm_c3", rd, 1'b0, 3'd0, 3'd0);
        push("rstm_c4", nop(), 1'b0, 3'd0, 3'd0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if ({stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel} !==
                {e.stall, e.flush, e.flush, e.fstg, e.rs_sel, e.rt_sel}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fl=%b%b stg=%b rs=%0d rt=%0d want stall=%b fl=%b stg=%b rs=%0d rt=%0d",
                         e.name, stall, flush_ifid, flush_idex, flush_stg, fwd_rs_sel, fwd_rt_sel,
                         e.stall, e.flush, e.fstg, e.rs_sel, e.rt_sel);
            end
            n_run++;
            if (stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d want %0d", e.name, stall_count, e.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // A self-dependent MUL held in ID stalls two of every three cycles; run long
    // enough for the counter to saturate and keep stalling past that point.
    task automatic test_saturation();
        int   bad;
        logic exp_st;
        bad = 0;
        apply(mk(0, ALU, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1));
        @(posedge clk);
        #1;
        model_cnt = 16'd0;
        apply(mk(1, MUL, 1, 5'd13, 5'd13, 1, 5'd0, 0, 0, 0));
        for (int i = 0; i < 98400; i++) begin
            @(negedge clk);
            if (i == 3000) begin
                n_run++;
                if (stall_count !== model_cnt) begin
                    n_fail++;
                    $display("FAIL sat_mid count: got %0d want %0d", stall_count, model_cnt);
                end
            end
            exp_st = (i % 3) != 0;
            if (stall !== exp_st) bad++;
            if (exp_st && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sat_pattern: got %0d wrong stall cycles want 0", bad);
        end
        n_run++;
        if (stall_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold count: got %h want ffff", stall_count);
        end
        @(posedge clk);
        #1;
        apply(nop());
    endtask

    initial begin
        apply(mk(0, ALU, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_mul_use();
        test_reg_zero();
        test_redirect();
        test_reset_mid_stall();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
